// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch handshake controller.
// Fetches the word at pc, holds it for decode, then advances, redirects or halts.
module fetch_sequencer #(
    parameter int unsigned    PC_W     = 16,
    parameter int unsigned    INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    pc_seq,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic               halted,
    output logic [15:0]        retired
);

    localparam int unsigned RET_W = 16;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [RET_W-1:0]   r_retired;
    logic               r_imem_req;
    logic               r_instr_valid;
    logic               r_halted;

    logic [1:0]         w_state_nx;
    logic [PC_W-1:0]    w_pc_nx;
    logic [PC_W-1:0]    w_pc_inc;
    logic               w_capture;
    logic               w_accept;

    assign w_pc_inc = r_pc + PC_W'(2);

    // Next state and pc; redirect targets are forced to halfword alignment.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_capture  = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_capture  = 1'b1;
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    w_accept = 1'b1;
                    if (halt_req) begin
                        w_state_nx = S_HALT;
                    end else begin
                        w_state_nx = S_FETCH;
                        w_pc_nx    = redirect ? (redirect_pc & ~PC_W'(1)) : w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_nx = S_HALT;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_retired     <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_imem_req    <= (w_state_nx == S_FETCH);
            r_instr_valid <= (w_state_nx == S_ISSUE);
            r_halted      <= (w_state_nx == S_HALT);
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_retired <= r_retired + RET_W'(1);
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_cur      = r_pc;
    assign pc_seq      = w_pc_inc;
    assign halted      = r_halted;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (RESET_PC=0 and RESET_PC=FFFE instances).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_req = 1'b0;
    logic [15:0] bias = 16'h0000;
    logic        imem_req, instr_valid, halted;
    logic [15:0] imem_addr, instr, pc_cur, pc_seq, retired;

    logic        rst2 = 1'b1;
    logic        valid2 = 1'b0;
    logic        ready2 = 1'b0;
    logic [15:0] rdata2;
    logic        req2, iv2, halted2;
    logic [15:0] addr2, instr2, pc_cur2, pc_seq2, retired2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Memory returns A000+addr (+bias) when valid, garbage otherwise.
    assign imem_rdata = imem_valid ? (16'hA000 + imem_addr + bias) : 16'hDEAD;
    assign rdata2     = valid2 ? 16'hB000 : 16'hDEAD;

    fetch_sequencer #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_cur(pc_cur),
        .pc_seq(pc_seq), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halted(halted), .retired(retired)
    );

    fetch_sequencer #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
        .imem_valid(valid2), .imem_rdata(rdata2), .instr(instr2),
        .instr_valid(iv2), .instr_ready(ready2), .pc_cur(pc_cur2),
        .pc_seq(pc_seq2), .redirect(1'b0), .redirect_pc(16'h0000),
        .halt_req(1'b0), .halted(halted2), .retired(retired2)
    );

    // Leaves the bench at a falling edge with the DUT in BOOT.
    task automatic do_reset();
        rst = 1'b1; imem_valid = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; halt_req = 1'b0; bias = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin $display("FAIL reset_req got %b exp 0", imem_req); n_fail++; end
        n_cmp++; if (instr_valid !== 1'b0) begin $display("FAIL reset_iv got %b exp 0", instr_valid); n_fail++; end
        n_cmp++; if (halted !== 1'b0) begin $display("FAIL reset_halted got %b exp 0", halted); n_fail++; end
        n_cmp++; if (imem_addr !== 16'h0000) begin $display("FAIL reset_addr got %h exp 0000", imem_addr); n_fail++; end
        n_cmp++; if (pc_cur !== 16'h0000) begin $display("FAIL reset_pc_cur got %h exp 0000", pc_cur); n_fail++; end
        n_cmp++; if (pc_seq !== 16'h0002) begin $display("FAIL reset_pc_seq got %h exp 0002", pc_seq); n_fail++; end
        n_cmp++; if (instr !== 16'h0000) begin $display("FAIL reset_instr got %h exp 0000", instr); n_fail++; end
        n_cmp++; if (retired !== 16'h0000) begin $display("FAIL reset_retired got %h exp 0000", retired); n_fail++; end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin $display("FAIL boot_req got %b exp 0", imem_req); n_fail++; end
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1) begin $display("FAIL first_req got %b exp 1", imem_req); n_fail++; end
        n_cmp++; if (imem_addr !== 16'h0000) begin $display("FAIL first_addr got %h exp 0000", imem_addr); n_fail++; end
    endtask

    task automatic test_zero_wait();
        do_reset();
        imem_valid = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                n_cmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                    $display("FAIL zw_fetch_flags k=%0d got req=%b iv=%b exp req=1 iv=0", k, imem_req, instr_valid); n_fail++; end
                n_cmp++; if (imem_addr !== 16'(k)) begin
                    $display("FAIL zw_addr k=%0d got %h exp %h", k, imem_addr, 16'(k)); n_fail++; end
            end else begin
                n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                    $display("FAIL zw_issue_flags k=%0d got req=%b iv=%b exp req=0 iv=1", k, imem_req, instr_valid); n_fail++; end
                n_cmp++; if (instr !== 16'hA000 + 16'(k - 1) || pc_cur !== 16'(k - 1)) begin
                    $display("FAIL zw_instr k=%0d got instr=%h pc=%h exp instr=%h pc=%h",
                             k, instr, pc_cur, 16'hA000 + 16'(k - 1), 16'(k - 1)); n_fail++; end
            end
        end
        @(negedge clk);
        n_cmp++; if (retired !== 16'd3) begin $display("FAIL zw_retired got %0d exp 3", retired); n_fail++; end
        n_cmp++; if (imem_addr !== 16'h0006) begin $display("FAIL zw_addr_after got %h exp 0006", imem_addr); n_fail++; end
    endtask

    task automatic test_wait_states();
        do_reset();
        imem_valid = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || instr_valid !== 1'b0) begin
                $display("FAIL ws_hold w=%0d got req=%b addr=%h iv=%b exp req=1 addr=0002 iv=0",
                         w, imem_req, imem_addr, instr_valid); n_fail++; end
            n_cmp++; if (instr !== 16'hA000) begin
                $display("FAIL ws_instr_kept w=%0d got %h exp a000", w, instr); n_fail++; end
            if (w == 3) imem_valid = 1'b1;
        end
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'hA002 || pc_cur !== 16'h0002) begin
            $display("FAIL ws_capture got iv=%b instr=%h pc=%h exp iv=1 instr=a002 pc=0002",
                     instr_valid, instr, pc_cur); n_fail++; end
    endtask

    task automatic test_stall();
        do_reset();
        imem_valid = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bias = 16'h0100; redirect = 1'b1; redirect_pc = 16'h0031;
        for (int s = 0; s < 5; s++) begin
            if (s != 0) @(negedge clk);
            n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                $display("FAIL stall_flags s=%0d got iv=%b req=%b exp iv=1 req=0", s, instr_valid, imem_req); n_fail++; end
            n_cmp++; if (instr !== 16'hA000 || pc_cur !== 16'h0000 || retired !== 16'd0) begin
                $display("FAIL stall_hold s=%0d got instr=%h pc=%h ret=%0d exp a000 0000 0",
                         s, instr, pc_cur, retired); n_fail++; end
        end
        redirect = 1'b0; instr_ready = 1'b1; bias = 16'h0000;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || retired !== 16'd1) begin
            $display("FAIL stall_release got req=%b addr=%h ret=%0d exp 1 0002 1",
                     imem_req, imem_addr, retired); n_fail++; end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_valid = 1'b1; instr_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (imem_addr !== 16'h0004 || imem_req !== 1'b1) begin
            $display("FAIL rd_pre_addr got %h req=%b exp 0004 1", imem_addr, imem_req); n_fail++; end
        redirect = 1'b1; redirect_pc = 16'h0031;
        @(negedge clk);
        n_cmp++; if (pc_cur !== 16'h0004 || pc_seq !== 16'h0006 || instr_valid !== 1'b1) begin
            $display("FAIL rd_issue got pc=%h seq=%h iv=%b exp 0004 0006 1", pc_cur, pc_seq, instr_valid); n_fail++; end
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (imem_addr !== 16'h0030 || imem_req !== 1'b1) begin
            $display("FAIL rd_target got addr=%h req=%b exp 0030 1", imem_addr, imem_req); n_fail++; end
        @(negedge clk);
        n_cmp++; if (instr !== 16'hA030 || pc_seq !== 16'h0032) begin
            $display("FAIL rd_fetch got instr=%h seq=%h exp a030 0032", instr, pc_seq); n_fail++; end
    endtask

    task automatic test_halt();
        do_reset();
        imem_valid = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (halted !== 1'b0) begin $display("FAIL halt_pre got %b exp 0", halted); n_fail++; end
        halt_req = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        halt_req = 1'b0; redirect = 1'b0;
        n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            $display("FAIL halt_enter got halted=%b req=%b iv=%b exp 1 0 0", halted, imem_req, instr_valid); n_fail++; end
        n_cmp++; if (retired !== 16'd1 || pc_cur !== 16'h0000) begin
            $display("FAIL halt_state got ret=%0d pc=%h exp 1 0000", retired, pc_cur); n_fail++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b0 || halted !== 1'b1 || retired !== 16'd1 || imem_addr !== 16'h0000) begin
                $display("FAIL halt_stay i=%0d got req=%b halted=%b ret=%0d addr=%h exp 0 1 1 0000",
                         i, imem_req, halted, retired, imem_addr); n_fail++; end
        end
    endtask

    task automatic test_wrap_and_midreset();
        rst2 = 1'b1; valid2 = 1'b1; ready2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        n_cmp++; if (req2 !== 1'b1 || addr2 !== 16'hFFFE || pc_seq2 !== 16'h0000) begin
            $display("FAIL wrap_first got req=%b addr=%h seq=%h exp 1 fffe 0000", req2, addr2, pc_seq2); n_fail++; end
        @(negedge clk);
        n_cmp++; if (iv2 !== 1'b1 || pc_cur2 !== 16'hFFFE || instr2 !== 16'hB000) begin
            $display("FAIL wrap_issue got iv=%b pc=%h instr=%h exp 1 fffe b000", iv2, pc_cur2, instr2); n_fail++; end
        @(negedge clk);
        valid2 = 1'b0;
        n_cmp++; if (req2 !== 1'b1 || addr2 !== 16'h0000 || retired2 !== 16'd1) begin
            $display("FAIL wrap_second got req=%b addr=%h ret=%0d exp 1 0000 1", req2, addr2, retired2); n_fail++; end
        @(negedge clk);
        n_cmp++; if (req2 !== 1'b1 || addr2 !== 16'h0000) begin
            $display("FAIL wrap_wait got req=%b addr=%h exp 1 0000", req2, addr2); n_fail++; end
        #2 rst2 = 1'b1;
        #1;
        n_cmp++; if (req2 !== 1'b0 || iv2 !== 1'b0 || halted2 !== 1'b0) begin
            $display("FAIL midrst_flags got req=%b iv=%b halted=%b exp 0 0 0", req2, iv2, halted2); n_fail++; end
        n_cmp++; if (addr2 !== 16'hFFFE || pc_cur2 !== 16'hFFFE || instr2 !== 16'h0000 || retired2 !== 16'd0) begin
            $display("FAIL midrst_vals got addr=%h pc=%h instr=%h ret=%0d exp fffe fffe 0000 0",
                     addr2, pc_cur2, instr2, retired2); n_fail++; end
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        n_cmp++; if (req2 !== 1'b0) begin $display("FAIL midrst_boot got req=%b exp 0", req2); n_fail++; end
        @(negedge clk);
        n_cmp++; if (req2 !== 1'b1 || addr2 !== 16'hFFFE) begin
            $display("FAIL midrst_restart got req=%b addr=%h exp 1 fffe", req2, addr2); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap_and_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequential controller that owns the program counter register and the instruction-fetch handshake of the processor core. It issues the current PC to instruction memory, waits for the fetched word, and holds it for decode. On decode acceptance it advances the PC: to the branch target from the branch-resolution logic when a redirect is signalled, otherwise to PC+2. It also implements the halt state and a retired-instruction counter.

## Interface
- PC_W, 16, width of PC and memory address
- INSTR_W, 16, instruction word width
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  PC_W  fetch address (equals PC)
- imem_valid  input  1  memory returns data this cycle
- imem_rdata  input  INSTR_W  fetched word, sampled when imem_req && imem_valid
- instr  output  INSTR_W  held instruction for decode
- instr_valid  output  1  instr/pc_cur are valid
- instr_ready  input  1  decode accepts the held instruction
- pc_cur  output  PC_W  PC of the held instruction
- pc_seq  output  PC_W  pc_cur+2, the fall-through address fed to branch resolution
- redirect  input  1  branch taken for the held instruction
- redirect_pc  input  PC_W  branch target
- halt_req  input  1  held instruction is HLT
- halted  output  1  core halted
- retired  output  16  count of accepted instructions

## Operation
- States: BOOT, FETCH, ISSUE, HALT. Reset enters BOOT.
- BOOT: all request/valid outputs 0; unconditionally go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc held stable until imem_valid. On imem_valid: instr<=imem_rdata, go to ISSUE. Zero-wait (valid in first request cycle) and multi-wait memories both supported; no cycle limit.
- ISSUE: instr_valid=1; instr, pc_cur stable until instr_ready. On instr_ready, priority: halt_req -> HALT, pc unchanged; else redirect -> pc<=redirect_pc with bit 0 forced to 0, go to FETCH; else pc<=pc+2, go to FETCH. retired increments on every accepted instruction, including HLT.
- HALT: halted=1, imem_req=0, instr_valid=0. Only rst exits.
- redirect and halt_req are sampled only in ISSUE with instr_ready=1; ignored in all other states.
- imem_valid outside FETCH is ignored; instr is not overwritten.
- Arithmetic: pc+2 and retired+1 are modulo 2^width; 16'hFFFE+2 wraps to 16'h0000; retired wraps 16'hFFFF->0.
- pc_seq = pc+2 (combinational, wrapping) in every state.

## Timing
- Reset values (asynchronous, immediate): pc=RESET_PC, instr=0, retired=0, state=BOOT, imem_req=0, instr_valid=0, halted=0, imem_addr=RESET_PC, pc_cur=RESET_PC.
- First imem_req rises in the second cycle after rst deasserts (BOOT occupies one cycle).
- Zero-wait memory, decode always ready: one instruction per 2 cycles (FETCH, ISSUE).
- Fetch latency: instr_valid asserts the cycle after the imem_valid edge.
- After acceptance in ISSUE, the next FETCH cycle presents the new pc on imem_addr.
- rst asserted mid-fetch or mid-issue: immediate return to reset values; the outstanding request is dropped (imem_req falls asynchronously).
- halted asserts the cycle after HLT acceptance and stays high.

## Test plan
- Reset, zero-wait memory returning 16'hA000+addr, instr_ready=1 -> imem_addr sequence 0000,0002,0004; instr_valid every other cycle; retired=3 after 3 issues.
- Memory with 3 wait states at addr 0002 -> imem_req and imem_addr=0002 held 4 cycles; instr captured only on the imem_valid cycle.
- At pc_cur=0004, redirect=1, redirect_pc=16'h0031 with instr_ready -> next imem_addr=16'h0030; pc_seq during issue was 16'h0006. redirect=1 without instr_ready -> no change.
- instr_ready held low 5 cycles in ISSUE -> instr, pc_cur stable; no new imem_req; retired unchanged.
- halt_req=1 and redirect=1 on same acceptance -> HALT wins; halted=1 next cycle; imem_req stays 0 for 10 cycles; retired incremented once.
- RESET_PC=16'hFFFE, no redirect -> second fetch address 16'h0000; rst pulsed during a wait-state fetch -> imem_req falls immediately; restart from BOOT at RESET_PC.
